// File: rtl/scratch_pad_bank_arbiter_pkg.sv
// Shared scratch_pad constants and width helpers.
// The bank controller and its arbiter both import this package.
package scratch_pad_bank_arbiter_pkg;

  localparam int SP_PORTS          = 8;
  localparam int SP_WIDTH          = 32;
  localparam int SP_FRAGMENT_DEPTH = 512;
  localparam int SP_REORDER_DEPTH  = 32;
  localparam int SP_RAM_LATENCY    = 1;

  // Bits needed to index n items, never less than 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int port_idx_width(input int ports);
    return clog2_min1(ports);
  endfunction

  localparam int SP_BANK_ADDR_WIDTH = clog2_min1(SP_FRAGMENT_DEPTH);
  localparam int SP_TAG_WIDTH       = clog2_min1(SP_REORDER_DEPTH);

endpackage

// File: rtl/scratch_pad_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer, then moves the pointer one past the winner.
module rr_arbiter
  import scratch_pad_bank_arbiter_pkg::*;
#(
  parameter int  N  = SP_PORTS,
  localparam int IW = port_idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [0:N-1]  req,
  output logic [0:N-1]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [0:N-1]  masked;
  logic          found;

  // Requests at or above the pointer win before the wrapped-around ones.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign masked[gi] = req[gi] && (gi >= int'(ptr_q));
    assign grant[gi]  = found && (grant_idx == IW'(gi));
  end

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && masked[i]) begin
        found     = 1'b1;
        grant_idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/scratch_pad_bank_arbiter.sv
// Per-bank scratch_pad controller: round-robin access to one single-port RAM,
// tracking reads through the RAM pipeline and returning tagged read data.
module scratch_pad_bank_arbiter
  import scratch_pad_bank_arbiter_pkg::*;
#(
  parameter int  PORTS           = SP_PORTS,
  parameter int  WIDTH           = SP_WIDTH,
  parameter int  BANK_ADDR_WIDTH = SP_BANK_ADDR_WIDTH,
  parameter int  TAG_WIDTH       = SP_TAG_WIDTH,
  parameter int  RAM_LATENCY     = SP_RAM_LATENCY,
  localparam int PIW             = port_idx_width(PORTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [0:PORTS-1]               req_valid,
  input  logic [0:PORTS-1]               req_we,
  input  logic [PORTS*BANK_ADDR_WIDTH-1:0] req_addr,
  input  logic [PORTS*WIDTH-1:0]         req_d,
  input  logic [PORTS*TAG_WIDTH-1:0]     req_tag,
  output logic [0:PORTS-1]               req_ready,
  input  logic [0:PORTS-1]               rsp_stall,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic [BANK_ADDR_WIDTH-1:0]     ram_addr,
  output logic [WIDTH-1:0]               ram_d,
  input  logic [WIDTH-1:0]               ram_q,
  output logic [0:PORTS-1]               rsp_valid,
  output logic [WIDTH-1:0]               rsp_q,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  output logic [31:0]                    conflict_count
);

  // Stage 0 is the issue stage; stages 1..LAST follow the RAM so that the
  // last one lines up with ram_q holding that access's data.
  localparam int LAST = RAM_LATENCY + 1;

  logic [0:PORTS-1]       eligible;
  logic [0:PORTS-1]       grant;
  logic [PIW-1:0]         grant_idx;
  logic                   any_grant;
  logic                   sel_we;
  logic                   multi_eligible;

  logic [BANK_ADDR_WIDTH-1:0] addr_a [PORTS];
  logic [WIDTH-1:0]           d_a    [PORTS];
  logic [TAG_WIDTH-1:0]       tag_a  [PORTS];

  logic                       ram_en_q, ram_en_d;
  logic                       ram_we_q, ram_we_d;
  logic [BANK_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0]           ram_d_q, ram_d_d;

  logic                       pipe_vld_q  [0:LAST];
  logic [PIW-1:0]             pipe_port_q [0:LAST];
  logic [TAG_WIDTH-1:0]       pipe_tag_q  [0:LAST];

  logic [0:PORTS-1]           rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]           rsp_q_q, rsp_q_d;
  logic [TAG_WIDTH-1:0]       rsp_tag_q, rsp_tag_d;
  logic [31:0]                conflict_q, conflict_d;

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    assign eligible[gi] = req_valid[gi] && (req_we[gi] || !rsp_stall[gi]);
    assign addr_a[gi]   = req_addr[(PORTS-gi)*BANK_ADDR_WIDTH-1 -: BANK_ADDR_WIDTH];
    assign d_a[gi]      = req_d[(PORTS-gi)*WIDTH-1 -: WIDTH];
    assign tag_a[gi]    = req_tag[(PORTS-gi)*TAG_WIDTH-1 -: TAG_WIDTH];
    assign rsp_valid_d[gi] = pipe_vld_q[LAST] && (pipe_port_q[LAST] == PIW'(gi));
  end

  rr_arbiter #(.N(PORTS)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready      = grant;
  assign any_grant      = |grant;
  assign sel_we         = req_we[grant_idx];
  // Clearing the lowest set bit leaves something only when two or more are set.
  assign multi_eligible = |(eligible & (eligible - PORTS'(1)));

  always_comb begin
    ram_en_d   = any_grant;
    ram_we_d   = any_grant && sel_we;
    ram_addr_d = any_grant ? addr_a[grant_idx] : ram_addr_q;
    ram_d_d    = any_grant ? d_a[grant_idx] : ram_d_q;
    rsp_q_d    = pipe_vld_q[LAST] ? ram_q : rsp_q_q;
    rsp_tag_d  = pipe_vld_q[LAST] ? pipe_tag_q[LAST] : rsp_tag_q;
    conflict_d = (multi_eligible && (conflict_q != '1)) ? conflict_q + 32'd1 : conflict_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_en_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_d_q        <= '0;
      pipe_vld_q[0]  <= 1'b0;
      pipe_port_q[0] <= '0;
      pipe_tag_q[0]  <= '0;
      rsp_valid_q    <= '0;
      rsp_q_q        <= '0;
      rsp_tag_q      <= '0;
      conflict_q     <= '0;
    end else begin
      ram_en_q       <= ram_en_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_d_q        <= ram_d_d;
      pipe_vld_q[0]  <= any_grant && !sel_we;
      pipe_port_q[0] <= grant_idx;
      pipe_tag_q[0]  <= tag_a[grant_idx];
      rsp_valid_q    <= rsp_valid_d;
      rsp_q_q        <= rsp_q_d;
      rsp_tag_q      <= rsp_tag_d;
      conflict_q     <= conflict_d;
    end
  end

  for (genvar gi = 1; gi <= LAST; gi++) begin : g_pipe
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pipe_vld_q[gi]  <= 1'b0;
        pipe_port_q[gi] <= '0;
        pipe_tag_q[gi]  <= '0;
      end else begin
        pipe_vld_q[gi]  <= pipe_vld_q[gi-1];
        pipe_port_q[gi] <= pipe_port_q[gi-1];
        pipe_tag_q[gi]  <= pipe_tag_q[gi-1];
      end
    end
  end

  assign ram_en         = ram_en_q;
  assign ram_we         = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_d          = ram_d_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_q          = rsp_q_q;
  assign rsp_tag        = rsp_tag_q;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_scratch_pad_bank_arbiter.sv
// Bench for scratch_pad_bank_arbiter: directed scenarios plus random traffic,
// checked every cycle against a grant-order reference model.
module tb_scratch_pad_bank_arbiter;

  localparam int P  = 8;
  localparam int W  = 32;
  localparam int AW = 9;
  localparam int TW = 5;
  localparam int RL = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [0:P-1]       req_valid, req_we, rsp_stall, req_ready, rsp_valid;
  logic [P*AW-1:0]    req_addr;
  logic [P*W-1:0]     req_d;
  logic [P*TW-1:0]    req_tag;
  logic               ram_en, ram_we;
  logic [AW-1:0]      ram_addr;
  logic [W-1:0]       ram_d;
  logic [W-1:0]       ram_q = '0;
  logic [W-1:0]       rsp_q;
  logic [TW-1:0]      rsp_tag;
  logic [31:0]        conflict_count;

  logic [AW-1:0]      p_addr [P];
  logic [W-1:0]       p_d    [P];
  logic [TW-1:0]      p_tag  [P];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < P; gi++) begin : g_pack
    assign req_addr[(P-gi)*AW-1 -: AW] = p_addr[gi];
    assign req_d[(P-gi)*W-1 -: W]      = p_d[gi];
    assign req_tag[(P-gi)*TW-1 -: TW]  = p_tag[gi];
  end

  scratch_pad_bank_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_d          (req_d),
    .req_tag        (req_tag),
    .req_ready      (req_ready),
    .rsp_stall      (rsp_stall),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_d          (ram_d),
    .ram_q          (ram_q),
    .rsp_valid      (rsp_valid),
    .rsp_q          (rsp_q),
    .rsp_tag        (rsp_tag),
    .conflict_count (conflict_count)
  );

  // Bank RAM seen by the DUT: samples at the edge after ram_en is set,
  // read data appears on ram_q RL cycles after that sampling edge.
  logic [W-1:0] bank_mem [0:(1<<AW)-1];
  logic [W-1:0] rd_pipe  [0:RL-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) bank_mem[ram_addr] <= ram_d;
      else        rd_pipe[0] <= bank_mem[ram_addr];
    end
    for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
    ram_q <= rd_pipe[RL-1];
  end

  // Reference model state
  typedef struct {
    longint      due;
    int          port;
    logic [TW-1:0] tag;
    logic [W-1:0]  data;
  } rsp_t;

  rsp_t          pend[$];
  logic [W-1:0]  ref_mem [0:(1<<AW)-1];
  int            mptr;
  logic [31:0]   mconf;
  longint        cyc;
  logic [0:P-1]  e_rsp_valid;
  logic [W-1:0]  e_rsp_q;
  logic [TW-1:0] e_rsp_tag;
  logic          e_ram_en, e_ram_we;
  logic [AW-1:0] e_ram_addr;
  logic [W-1:0]  e_ram_d;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit elig(input int p);
    return req_valid[p] && (req_we[p] || !rsp_stall[p]);
  endfunction

  function automatic int model_grant();
    for (int off = 0; off < P; off++) begin
      if (elig((mptr + off) % P)) return (mptr + off) % P;
    end
    return -1;
  endfunction

  function automatic logic [0:P-1] onehot(input int p);
    logic [0:P-1] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    mptr = 0; mconf = '0; pend.delete();
    e_rsp_valid = '0; e_rsp_q = '0; e_rsp_tag = '0;
    e_ram_en = 1'b0; e_ram_we = 1'b0; e_ram_addr = '0; e_ram_d = '0;
  endtask

  // Called at a falling edge with inputs already driven; checks, then
  // advances one rising edge and updates the model.
  task automatic cycle();
    int g;
    int ne;
    logic [0:P-1] exp_ready;
    if (!rst) model_reset();
    #1;
    g = rst ? model_grant() : -1;
    exp_ready = (g >= 0) ? onehot(g) : '0;
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, e_rsp_valid);
    check("rsp_q", rsp_q, e_rsp_q);
    check("rsp_tag", rsp_tag, e_rsp_tag);
    check("ram_en", ram_en, e_ram_en);
    check("ram_we", ram_we, e_ram_we);
    check("ram_addr", ram_addr, e_ram_addr);
    check("ram_d", ram_d, e_ram_d);
    check("conflict_count", conflict_count, mconf);
    @(posedge clk);
    cyc++;
    if (rst) begin
      ne = 0;
      for (int p = 0; p < P; p++) ne += elig(p);
      if (ne >= 2 && mconf != 32'hFFFF_FFFF) mconf++;
      e_rsp_valid = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        rsp_t r;
        r = pend.pop_front();
        e_rsp_valid = onehot(r.port);
        e_rsp_q = r.data;
        e_rsp_tag = r.tag;
        $display("[TB] cycle %0d rsp port %0d tag %0d data %h", cyc, r.port, r.tag, r.data);
      end
      if (g >= 0) begin
        e_ram_en = 1'b1;
        e_ram_we = req_we[g];
        e_ram_addr = p_addr[g];
        e_ram_d = p_d[g];
        if (req_we[g]) ref_mem[p_addr[g]] = p_d[g];
        else pend.push_back('{due: cyc + RL + 2, port: g, tag: p_tag[g], data: ref_mem[p_addr[g]]});
        mptr = (g + 1) % P;
      end else begin
        e_ram_en = 1'b0;
        e_ram_we = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_we = '0; rsp_stall = '0;
    for (int i = 0; i < P; i++) begin
      p_addr[i] = '0; p_d[i] = '0; p_tag[i] = '0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) cycle();
    rst = 1'b1;
  endtask

  initial begin
    logic [0:P-1] seen;
    cyc = 0;
    for (int a = 0; a < (1 << AW); a++) begin
      bank_mem[a] = '0;
      ref_mem[a]  = '0;
    end
    rd_pipe[0] = '0;
    idle_inputs();
    model_reset();
    rst = 1'b0;
    @(negedge clk);

    // Reset held, then idle
    do_reset(10);
    repeat (20) cycle();

    // Single port: write 42 to addr 5, then read it back
    req_valid = onehot(0); req_we[0] = 1'b1; p_addr[0] = 9'd5; p_d[0] = 32'd42;
    cycle();
    #1;
    check("single_wr_pulse", {ram_en, ram_we}, 2'b11);
    req_we[0] = 1'b0; p_tag[0] = 5'd3; p_d[0] = '0;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    #1;
    check("single_rd_not_early", rsp_valid, '0);
    cycle();
    #1;
    check("single_rd_valid", rsp_valid, onehot(0));
    check("single_rd_data", rsp_q, 32'd42);
    check("single_rd_tag", rsp_tag, 5'd3);
    repeat (3) cycle();

    // Fairness: every port reads continuously from a fresh pointer
    do_reset(2);
    for (int i = 0; i < P; i++) begin
      p_addr[i] = AW'(i); p_tag[i] = TW'(i);
    end
    req_valid = '1;
    for (int i = 0; i < 80; i++) begin
      #1;
      check("fair_grant", req_ready, onehot(i % P));
      cycle();
    end
    #1;
    check("fair_conflict80", conflict_count, 32'd80);
    idle_inputs();
    repeat (5) cycle();

    // Stall masking
    req_valid = onehot(2) | onehot(3); rsp_stall = onehot(2);
    #1;
    check("stall_only3", req_ready, onehot(3));
    cycle();
    req_valid = onehot(2); req_we = onehot(2); p_d[2] = 32'hABCD_0002; p_addr[2] = 9'd77;
    #1;
    check("stall_write2", req_ready, onehot(2));
    cycle();
    req_valid = onehot(2) | onehot(3); req_we = '0; rsp_stall = '0; p_tag[2] = 5'd9;
    repeat (4) cycle();
    idle_inputs();
    repeat (5) cycle();

    // Reset mid-operation: three reads, then reset right after the last accept
    do_reset(2);
    req_valid = onehot(1); p_addr[1] = 9'd5;
    for (int i = 0; i < 3; i++) begin
      p_tag[1] = TW'(20 + i);
      cycle();
    end
    idle_inputs();
    rst = 1'b0;
    seen = '0;
    repeat (2) begin
      cycle();
      seen |= rsp_valid;
    end
    rst = 1'b1;
    repeat (6) begin
      cycle();
      seen |= rsp_valid;
    end
    check("midrst_no_rsp", seen, '0);
    req_valid = onehot(0) | onehot(5);
    #1;
    check("midrst_ptr0", req_ready, onehot(0));
    cycle();
    idle_inputs();
    repeat (5) cycle();

    // Random traffic
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < P; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 60);
        req_we[i]    = $urandom_range(0, 1);
        rsp_stall[i] = ($urandom_range(0, 99) < 20);
        p_addr[i]    = $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 511));
        p_d[i]       = $urandom;
        p_tag[i]     = TW'($urandom_range(0, 31));
      end
      cycle();
    end
    idle_inputs();
    repeat (6) cycle();
    check("drain_empty", pend.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
